// File: rtl/score_pkg.sv
// Shared constants for the score_keeper slice: verdict codes from Decision,
// game-state encodings and the counter width.
package score_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Verdict codes produced by Decision
    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_WRONG   = 2'b01;
    localparam logic [1:0] RES_CORRECT = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    // Game state encodings, visible on the state output
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOSE = 2'b11;

endpackage

// File: rtl/score_keeper_verdict_edge.sv
// verdict_edge: registers the previous verdict and flags the first cycle of
// each new nonzero verdict as a round event. A verdict held for many cycles,
// or a direct change between two nonzero codes, produces no further event.
module verdict_edge
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] result,
    output logic       evt,
    output logic [1:0] code
);

    logic [1:0] res_q;

    // Track the previous verdict every cycle, regardless of game state
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= RES_NONE;
        end else begin
            res_q <= result;
        end
    end

    // Event on the rising side of a verdict: nonzero now, none last cycle
    always_comb begin
        evt  = (result != RES_NONE) && (res_q == RES_NONE);
        code = result;
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: round/score bookkeeping downstream of Decision.
// Counts hits and misses per game, declares WIN or LOSE, and keeps an
// optional hit streak when the SCORE_STREAK_EN macro is defined (otherwise
// streak and best_streak are tied to zero).
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned ROUNDS    = 8,
    parameter int unsigned WIN_SCORE = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       result,
    input  logic             start,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] rounds,
    output logic             game_over,
    output logic             err,
    output logic [CNT_W-1:0] streak,
    output logic [CNT_W-1:0] best_streak
);

    logic             evt;
    logic [1:0]       code;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] hits_n;
    logic [CNT_W-1:0] misses_n;
    logic [CNT_W-1:0] rounds_n;
    logic             err_n;
    logic             clear;
    logic             count;

    verdict_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .evt    (evt),
        .code   (code)
    );

    // Next-state and counter update; start overrides any coincident event
    always_comb begin
        state_n  = state;
        hits_n   = hits;
        misses_n = misses;
        rounds_n = rounds;
        err_n    = err;
        clear    = 1'b0;
        count    = 1'b0;

        case (state)
            ST_PLAY: begin
                if (start) begin
                    clear = 1'b1;
                end else if (evt) begin
                    count = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    clear   = 1'b1;
                    state_n = ST_PLAY;
                end
            end
        endcase

        if (count) begin
            rounds_n = rounds + CNT_ONE;
            if (code == RES_CORRECT) begin
                hits_n = hits + CNT_ONE;
            end else begin
                misses_n = misses + CNT_ONE;
            end
            if (code == RES_INVALID) begin
                err_n = 1'b1;
            end
            // Win is checked first so a final-round win beats the round limit
            if (hits_n == CNT_W'(WIN_SCORE)) begin
                state_n = ST_WIN;
            end else if (rounds_n == CNT_W'(ROUNDS)) begin
                state_n = ST_LOSE;
            end
        end

        if (clear) begin
            hits_n   = '0;
            misses_n = '0;
            rounds_n = '0;
            err_n    = 1'b0;
        end
    end

    // Register game state, counters and the derived game_over flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hits      <= '0;
            misses    <= '0;
            rounds    <= '0;
            err       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            hits      <= hits_n;
            misses    <= misses_n;
            rounds    <= rounds_n;
            err       <= err_n;
            game_over <= (state_n == ST_WIN) || (state_n == ST_LOSE);
        end
    end

`ifdef SCORE_STREAK_EN
    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] best_q;
    logic [CNT_W-1:0] streak_inc;

    assign streak_inc = streak_q + CNT_ONE;

    // Consecutive-hit tracking, cleared with the other counters on start
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            streak_q <= '0;
            best_q   <= '0;
        end else if (count) begin
            if (code == RES_CORRECT) begin
                streak_q <= streak_inc;
                if (streak_inc > best_q) begin
                    best_q <= streak_inc;
                end
            end else begin
                streak_q <= '0;
            end
        end
    end

    assign streak      = streak_q;
    assign best_streak = best_q;
`else
    assign streak      = '0;
    assign best_streak = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper. A behavioural game model runs in the
// stimulus task and queues the expected outputs for every clock; a monitor
// pops and compares them after each rising edge. Scenario tasks add direct
// checks of the headline values for each game situation.
module tb_score_keeper;
    import score_pkg::*;

    localparam int unsigned TB_ROUNDS = 8;
    localparam int unsigned TB_WIN    = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] result = 2'b00;
    logic [1:0] state;
    logic [3:0] hits, misses, rounds, streak, best_streak;
    logic       game_over, err;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] h;
        logic [3:0] m;
        logic [3:0] r;
        logic       go;
        logic       er;
        logic [3:0] sk;
        logic [3:0] bs;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_a;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [1:0] m_st   = ST_IDLE;
    logic [1:0] m_resq = 2'b00;
    int         m_h = 0, m_m = 0, m_r = 0, m_sk = 0, m_bs = 0;
    logic       m_er = 1'b0;

    always #5 clk = ~clk;

    score_keeper #(
        .ROUNDS    (TB_ROUNDS),
        .WIN_SCORE (TB_WIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .result      (result),
        .start       (start),
        .state       (state),
        .hits        (hits),
        .misses      (misses),
        .rounds      (rounds),
        .game_over   (game_over),
        .err         (err),
        .streak      (streak),
        .best_streak (best_streak)
    );

    // Scoreboard consumer: one comparison per clock that had stimulus queued
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_a = '{state, hits, misses, rounds, game_over, err, streak, best_streak};
            n_checks++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL sb_outputs @%0t: got st=%0d h=%0d m=%0d r=%0d go=%0b err=%0b sk=%0d bs=%0d, expected st=%0d h=%0d m=%0d r=%0d go=%0b err=%0b sk=%0d bs=%0d",
                         $time, mon_a.st, mon_a.h, mon_a.m, mon_a.r, mon_a.go, mon_a.er, mon_a.sk, mon_a.bs,
                         mon_e.st, mon_e.h, mon_e.m, mon_e.r, mon_e.go, mon_e.er, mon_e.sk, mon_e.bs);
            end
        end
    end

    // Drive one clock of stimulus, advance the model, queue its expectation
    task automatic cyc(input logic r, input logic s, input logic [1:0] res);
        logic ev;
        exp_t e;
        rst    = r;
        start  = s;
        result = res;
        if (r) begin
            m_st = ST_IDLE; m_resq = 2'b00; m_er = 1'b0;
            m_h = 0; m_m = 0; m_r = 0; m_sk = 0; m_bs = 0;
        end else begin
            ev     = (res != 2'b00) && (m_resq == 2'b00);
            m_resq = res;
            if (s) begin
                m_st = ST_PLAY; m_er = 1'b0;
                m_h = 0; m_m = 0; m_r = 0; m_sk = 0; m_bs = 0;
            end else if (m_st == ST_PLAY && ev) begin
                m_r++;
                if (res == 2'b10) begin
                    m_h++;
                    m_sk++;
                    if (m_sk > m_bs) m_bs = m_sk;
                end else begin
                    m_m++;
                    m_sk = 0;
                end
                if (res == 2'b11) m_er = 1'b1;
                if (m_h == TB_WIN) m_st = ST_WIN;
                else if (m_r == TB_ROUNDS) m_st = ST_LOSE;
            end
        end
        e.st = m_st;
        e.h  = 4'(m_h);
        e.m  = 4'(m_m);
        e.r  = 4'(m_r);
        e.go = (m_st == ST_WIN) || (m_st == ST_LOSE);
        e.er = m_er;
`ifdef SCORE_STREAK_EN
        e.sk = 4'(m_sk);
        e.bs = 4'(m_bs);
`else
        e.sk = 4'd0;
        e.bs = 4'd0;
`endif
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b1, 2'b10);
        n_checks++;
        if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++;
        if ({hits, misses, rounds} !== 12'h000) begin n_fail++; $display("FAIL reset_counters: got %h expected 000", {hits, misses, rounds}); end
        n_checks++;
        if ({game_over, err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {game_over, err}); end
        cyc(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_mixed();
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b01); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if ({hits, misses, rounds} !== {4'd3, 4'd1, 4'd4}) begin
            n_fail++; $display("FAIL mixed_counts: got h=%0d m=%0d r=%0d expected 3 1 4", hits, misses, rounds);
        end
        n_checks++;
        if (state !== ST_PLAY) begin n_fail++; $display("FAIL mixed_state: got %0d expected 1", state); end
    endtask

    task automatic test_win();
        cyc(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 2'b10);
            cyc(1'b0, 1'b0, 2'b00);
        end
        cyc(1'b0, 1'b0, 2'b10);
        n_checks++;
        if (state !== ST_WIN) begin n_fail++; $display("FAIL win_state: got %0d expected 2", state); end
        n_checks++;
        if (game_over !== 1'b1) begin n_fail++; $display("FAIL win_game_over: got %b expected 1", game_over); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 2'b00);
            cyc(1'b0, 1'b0, 2'b10);
        end
        cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if (hits !== 4'd5 || rounds !== 4'd5) begin
            n_fail++; $display("FAIL win_hold: got h=%0d r=%0d expected 5 5", hits, rounds);
        end
    endtask

    task automatic test_lose();
        cyc(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, (i % 2 == 0) ? 2'b10 : 2'b01);
            cyc(1'b0, 1'b0, 2'b00);
        end
        n_checks++;
        if (state !== ST_LOSE || game_over !== 1'b1) begin
            n_fail++; $display("FAIL lose_state: got st=%0d go=%b expected 3 1", state, game_over);
        end
        n_checks++;
        if ({hits, misses, rounds} !== {4'd4, 4'd4, 4'd8}) begin
            n_fail++; $display("FAIL lose_counts: got h=%0d m=%0d r=%0d expected 4 4 8", hits, misses, rounds);
        end
    endtask

    task automatic test_hold();
        cyc(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'b10);
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b11);
        cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if ({hits, misses, rounds} !== {4'd1, 4'd1, 4'd2}) begin
            n_fail++; $display("FAIL hold_counts: got h=%0d m=%0d r=%0d expected 1 1 2", hits, misses, rounds);
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL hold_err: got %b expected 1", err); end
        cyc(1'b0, 1'b0, 2'b01);
        cyc(1'b0, 1'b0, 2'b10);
        cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if (rounds !== 4'd3 || misses !== 4'd2) begin
            n_fail++; $display("FAIL direct_change: got r=%0d m=%0d expected 3 2", rounds, misses);
        end
    endtask

    task automatic test_start_event();
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b11); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 2'b10);
        n_checks++;
        if ({hits, misses, rounds, err} !== 13'h0) begin
            n_fail++; $display("FAIL start_event_counts: got h=%0d m=%0d r=%0d err=%b expected 0 0 0 0", hits, misses, rounds, err);
        end
        n_checks++;
        if (state !== ST_PLAY) begin n_fail++; $display("FAIL start_event_state: got %0d expected 1", state); end
        cyc(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_rst_mid();
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b01);
        cyc(1'b1, 1'b1, 2'b10);
        n_checks++;
        if (state !== ST_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
        n_checks++;
        if ({hits, misses, rounds} !== 12'h000) begin
            n_fail++; $display("FAIL rst_mid_counts: got h=%0d m=%0d r=%0d expected 0 0 0", hits, misses, rounds);
        end
        cyc(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_idle_present();
        cyc(1'b0, 1'b0, 2'b10);
        cyc(1'b0, 1'b1, 2'b10);
        cyc(1'b0, 1'b0, 2'b10);
        cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if (rounds !== 4'd0 || state !== ST_PLAY) begin
            n_fail++; $display("FAIL idle_present: got r=%0d st=%0d expected 0 1", rounds, state);
        end
        cyc(1'b0, 1'b0, 2'b10);
        cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if (rounds !== 4'd1) begin n_fail++; $display("FAIL idle_then_round: got %0d expected 1", rounds); end
    endtask

    task automatic test_streak();
        logic [3:0] exp_sk;
        logic [3:0] exp_bs;
`ifdef SCORE_STREAK_EN
        exp_sk = 4'd1;
        exp_bs = 4'd3;
`else
        exp_sk = 4'd0;
        exp_bs = 4'd0;
`endif
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b01); cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b10); cyc(1'b0, 1'b0, 2'b00);
        n_checks++;
        if (streak !== exp_sk) begin n_fail++; $display("FAIL streak_value: got %0d expected %0d", streak, exp_sk); end
        n_checks++;
        if (best_streak !== exp_bs) begin n_fail++; $display("FAIL best_streak_value: got %0d expected %0d", best_streak, exp_bs); end
        n_checks++;
        if (hits !== 4'd4 || state !== ST_PLAY) begin
            n_fail++; $display("FAIL streak_game: got h=%0d st=%0d expected 4 1", hits, state);
        end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_win();
        test_lose();
        test_hold();
        test_start_event();
        test_rst_mid();
        test_idle_present();
        test_streak();
        cyc(1'b0, 1'b0, 2'b00);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
